friscv_apb_initiator: RTL and testbench

// - Initiator end of the friscv peripheral port (en/wr/addr/wdata/strb -> rdata/ready) used by friscv_gpios.
// - Converts a valid/ready request channel from the core/LSU into single peripheral transfers.
// - Returns exactly one response per request on a valid/ready response channel.
// - One transfer outstanding; sits between the load/store path and the peripheral interconnect.

---
 rtl/friscv_pkg.sv | 14 +
 rtl/friscv_apb_initiator_if.sv | 42 ++++
 rtl/friscv_apb_watchdog.sv | 30 +++
 rtl/friscv_apb_initiator.sv | 149 ++++++++++++++
 tb/tb_friscv_apb_initiator.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/friscv_pkg.sv
// Shared friscv definitions: APB initiator FSM states and the zero read-data value
// returned on writes and aborted transfers.
package friscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDATA,
    RESP
  } apb_init_state_t;

  localparam int APB_ZERO_RDATA = 0;

endpackage

// File: rtl/friscv_apb_initiator_if.sv
// Request/response channels plus peripheral port of the APB initiator.
// The master modport is the initiator; slave is the core + peripheral side.
interface friscv_apb_initiator_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDRW-1:0]  req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              per_en;
  logic              per_wr;
  logic [ADDRW-1:0]  per_addr;
  logic [XLEN-1:0]   per_wdata;
  logic [XLEN/8-1:0] per_strb;
  logic [XLEN-1:0]   per_rdata;
  logic              per_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_strb,
    input  rsp_ready, per_rdata, per_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output per_en, per_wr, per_addr, per_wdata, per_strb
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_strb,
    output rsp_ready, per_rdata, per_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  per_en, per_wr, per_addr, per_wdata, per_strb
  );

endinterface

// File: rtl/friscv_apb_watchdog.sv
// ACCESS-phase watchdog: counts cycles spent in ACCESS and flags the TIMEOUT-th one.
// Instantiated only when FRISCV_APB_TIMEOUT_EN is defined.
module friscv_apb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic srst,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  // Held at zero outside ACCESS, so every ACCESS phase starts counting from 0
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_count <= '0;
    end else if (srst || !i_run) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/friscv_apb_initiator.sv
// Converts valid/ready requests into single peripheral transfers, one outstanding.
// Define FRISCV_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles with rsp_err=1.
module friscv_apb_initiator
  import friscv_pkg::*;
#(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  friscv_apb_initiator_if.master bus
);

  localparam logic [XLEN-1:0] ZERO_RDATA = XLEN'(APB_ZERO_RDATA);

  apb_init_state_t   r_state, w_next_state;
  logic              r_per_en, w_per_en;
  logic              r_per_wr, w_per_wr;
  logic [ADDRW-1:0]  r_per_addr, w_per_addr;
  logic [XLEN-1:0]   r_per_wdata, w_per_wdata;
  logic [XLEN/8-1:0] r_per_strb, w_per_strb;
  logic              r_rsp_valid, w_rsp_valid;
  logic [XLEN-1:0]   r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic              w_handshake;
  logic              w_timeout;

  assign w_handshake = r_per_en && bus.per_ready;

`ifdef FRISCV_APB_TIMEOUT_EN
  friscv_apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .i_run     (r_state == ACCESS),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT < 2);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_per_en     = r_per_en;
    w_per_wr     = r_per_wr;
    w_per_addr   = r_per_addr;
    w_per_wdata  = r_per_wdata;
    w_per_strb   = r_per_strb;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_rdata  = r_rsp_rdata;
    w_rsp_err    = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_per_en     = 1'b1;
          w_per_wr     = bus.req_wr;
          w_per_addr   = bus.req_addr;
          w_per_wdata  = bus.req_wdata;
          w_per_strb   = bus.req_strb;
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        // A completing handshake takes priority over a same-cycle timeout
        if (w_handshake) begin
          w_per_en = 1'b0;
          if (r_per_wr) begin
            w_rsp_valid  = 1'b1;
            w_rsp_rdata  = ZERO_RDATA;
            w_rsp_err    = 1'b0;
            w_next_state = RESP;
          end else begin
            w_next_state = RDATA;
          end
        end else if (w_timeout) begin
          w_per_en     = 1'b0;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = ZERO_RDATA;
          w_rsp_err    = 1'b1;
          w_next_state = RESP;
        end
      end
      RDATA: begin
        w_rsp_valid  = 1'b1;
        w_rsp_rdata  = bus.per_rdata;
        w_rsp_err    = 1'b0;
        w_next_state = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_per_en    <= 1'b0;
      r_per_wr    <= 1'b0;
      r_per_addr  <= '0;
      r_per_wdata <= '0;
      r_per_strb  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (srst) begin
      r_state     <= IDLE;
      r_per_en    <= 1'b0;
      r_per_wr    <= 1'b0;
      r_per_addr  <= '0;
      r_per_wdata <= '0;
      r_per_strb  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_per_en    <= w_per_en;
      r_per_wr    <= w_per_wr;
      r_per_addr  <= w_per_addr;
      r_per_wdata <= w_per_wdata;
      r_per_strb  <= w_per_strb;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.per_en    = r_per_en;
  assign bus.per_wr    = r_per_wr;
  assign bus.per_addr  = r_per_addr;
  assign bus.per_wdata = r_per_wdata;
  assign bus.per_strb  = r_per_strb;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_friscv_apb_initiator.sv
// Directed bench for friscv_apb_initiator with a small gpio-like peripheral model.
// The timeout step follows FRISCV_APB_TIMEOUT_EN when the build defines it.
module tb_friscv_apb_initiator;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  logic aclk;
  logic aresetn;
  logic srst;

  int n_vec = 0;
  int n_bad = 0;

  int          slave_wait;
  bit          slave_stall;
  int          wcnt;
  logic [31:0] gpio_in;
  logic [31:0] mem [16];
  logic [31:0] exp_mem [16];

  friscv_apb_initiator_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus ();

  friscv_apb_initiator #(
    .ADDRW   (ADDRW),
    .XLEN    (XLEN),
    .TIMEOUT (16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (st[b]) m[b*8 +: 8] = nw[b*8 +: 8];
    return m;
  endfunction

  // Peripheral: registered ready after slave_wait extra cycles, registered read data
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.per_ready <= 1'b0;
      bus.per_rdata <= '0;
      wcnt          <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (bus.per_en && !bus.per_ready) begin
        if (!slave_stall) begin
          if (wcnt >= slave_wait) begin
            bus.per_ready <= 1'b1;
            wcnt          <= 0;
          end else begin
            wcnt <= wcnt + 1;
          end
        end
      end else begin
        bus.per_ready <= 1'b0;
        wcnt          <= 0;
      end
      if (bus.per_en && bus.per_ready) begin
        if (bus.per_wr)
          mem[bus.per_addr[3:0]] <= merge(mem[bus.per_addr[3:0]], bus.per_wdata, bus.per_strb);
        else
          bus.per_rdata <= (bus.per_addr == 16'h0001) ? gpio_in : mem[bus.per_addr[3:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_strb  = st;
  endtask

  // Called at a negedge; returns at the negedge after the response handshake
  task automatic transact(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic er);
    int t;
    bit got;
    bit hs;
    drive_req(wr, a, wd, st);
    t = 0;
    while (!bus.req_ready && t < 20) begin
      @(negedge aclk);
      t++;
    end
    check("req_accept_bound", 32'(t < 20), 32'd1);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    got = 1'b0;
    t   = 0;
    rd  = 'x;
    er  = 1'bx;
    while (!got && t < 200) begin
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      hs = bus.rsp_valid && bus.rsp_ready;
      if (hs) begin
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
      end
      @(negedge aclk);
      t++;
      if (hs) got = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    check("rsp_bound", 32'(got), 32'd1);
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] held;
  int          cnt;
  int          t;
  logic        rwr;
  logic [15:0] raddr;
  logic [31:0] rwd;
  logic [3:0]  rst_b;

  initial begin
    aresetn       = 1'b0;
    srst          = 1'b0;
    slave_wait    = 0;
    slave_stall   = 1'b0;
    gpio_in       = 32'h1234_5678;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    repeat (3) @(negedge aclk);

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_per_en", 32'(bus.per_en), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_per_addr", 32'(bus.per_addr), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Write to gpio_out: cycle 0 accept, per_en cycles 1-2, rsp_valid cycle 3
    drive_req(1'b1, 16'h0000, 32'hA5A5_5A5A, 4'hF);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    check("wr_c1_per_en", 32'(bus.per_en), 32'd1);
    check("wr_c1_per_wr", 32'(bus.per_wr), 32'd1);
    check("wr_c1_per_wdata", bus.per_wdata, 32'hA5A5_5A5A);
    check("wr_c1_per_strb", 32'(bus.per_strb), 32'hF);
    check("wr_c1_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge aclk);
    check("wr_c2_per_en", 32'(bus.per_en), 32'd1);
    check("wr_c2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge aclk);
    check("wr_c3_per_en", 32'(bus.per_en), 32'd0);
    check("wr_c3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("wr_c3_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("wr_c3_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("wr_gpio_out", mem[0], 32'hA5A5_5A5A);
    bus.rsp_ready = 1'b1;
    @(negedge aclk);
    bus.rsp_ready = 1'b0;
    check("wr_c4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("wr_c4_req_ready", 32'(bus.req_ready), 32'd1);

    // Read gpio_in: rsp_valid at cycle 4, then hold rsp_ready low 5 cycles
    drive_req(1'b0, 16'h0001, 32'h0, 4'h0);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    check("rd_c1_per_en", 32'(bus.per_en), 32'd1);
    check("rd_c1_per_wr", 32'(bus.per_wr), 32'd0);
    check("rd_c1_per_addr", 32'(bus.per_addr), 32'h1);
    @(negedge aclk);
    check("rd_c2_per_en", 32'(bus.per_en), 32'd1);
    @(negedge aclk);
    check("rd_c3_per_en", 32'(bus.per_en), 32'd0);
    check("rd_c3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge aclk);
    check("rd_c4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_c4_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    check("rd_c4_rsp_err", 32'(bus.rsp_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_per_en", 32'(bus.per_en), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge aclk);
    bus.rsp_ready = 1'b0;
    check("hold_release", 32'(bus.rsp_valid), 32'd0);

    // Peripheral never ready
    slave_stall = 1'b1;
    drive_req(1'b1, 16'h000F, 32'hDEAD_BEEF, 4'hF);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    cnt = 0;
    t   = 0;
`ifdef FRISCV_APB_TIMEOUT_EN
    while (bus.per_en && t < 40) begin
      cnt++;
      @(negedge aclk);
      t++;
    end
    check("to_per_en_cycles", 32'(cnt), 32'd16);
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to_rsp_rdata", bus.rsp_rdata, 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge aclk);
    bus.rsp_ready = 1'b0;
    check("to_release", 32'(bus.rsp_valid), 32'd0);
    slave_stall = 1'b0;
`else
    while (bus.per_en && !bus.rsp_valid && t < 30) begin
      cnt++;
      @(negedge aclk);
      t++;
    end
    check("stall_per_en_cycles", 32'(cnt), 32'd30);
    slave_stall   = 1'b0;
    bus.rsp_ready = 1'b1;
    t = 0;
    while (!bus.rsp_valid && t < 10) begin
      @(negedge aclk);
      t++;
    end
    check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("stall_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge aclk);
    bus.rsp_ready = 1'b0;
    check("stall_release", 32'(bus.rsp_valid), 32'd0);
`endif

    // srst during ACCESS drops the request; the next one completes
    slave_stall = 1'b1;
    drive_req(1'b0, 16'h0000, 32'h0, 4'h0);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    @(negedge aclk);
    check("srst_pre_per_en", 32'(bus.per_en), 32'd1);
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    check("srst_per_en", 32'(bus.per_en), 32'd0);
    check("srst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("srst_req_ready", 32'(bus.req_ready), 32'd1);
    slave_stall = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      check("srst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    transact(1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
    check("post_srst_rdata", rd, 32'hA5A5_5A5A);
    check("post_srst_err", 32'(er), 32'd0);

    // Mixed traffic with random wait states and back-pressure
    for (int i = 0; i < 60; i++) begin
      slave_wait = $urandom_range(0, 3);
      rwr   = 1'($urandom_range(0, 1));
      raddr = 16'($urandom_range(2, 9));
      rwd   = $urandom;
      rst_b = 4'($urandom_range(1, 15));
      transact(rwr, raddr, rwd, rst_b, rd, er);
      if (rwr) begin
        exp_mem[raddr[3:0]] = merge(exp_mem[raddr[3:0]], rwd, rst_b);
        check("rnd_wr_rdata", rd, 32'd0);
      end else begin
        check("rnd_rd_rdata", rd, exp_mem[raddr[3:0]]);
      end
      check("rnd_err", 32'(er), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
